inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Parametrised instruction-fetch front end for the 5-stage pipeline. It replaces the bare PC/PCAdder/ROM/IF-ID register path.
- Owns the PC and issues sequential requests to an instruction memory over a valid/ready interface.
- Buffers returned instructions in a DEPTH-entry prefetch queue and hands them to ID with a valid/ready handshake.
- On branch/jump redirect: flushes the queue and discards in-flight stale responses.

Parameters:
ADDR_W, 32, PC / memory address width
DATA_W, 32, instruction width
DEPTH, 4, queue entries and max outstanding requests; power of two, >=2
RESET_PC, 0, PC value loaded on reset

Ports:
CLK  input  1  clock; all state changes on rising edge
Reset  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  ADDR_W  fetch address (current PC)
imem_rsp_valid  input  1  response valid; one per accepted request, in order, >=1 cycle after acceptance
imem_rsp_data  input  DATA_W  returned instruction
redirect_valid  input  1  branch/jump taken this cycle
redirect_addr  input  ADDR_W  new PC
inst_valid  output  1  queue head valid
inst_ready  input  1  ID consumes head
inst_data  output  DATA_W  head instruction
inst_pc  output  ADDR_W  head instruction address
inst_pc_next  output  ADDR_W  inst_pc+4, mod 2^ADDR_W
queue_count  output  $clog2(DEPTH)+1  occupied entries
perf_flush_cnt  output  16  present only with IFQ_PERF_CNT_EN
perf_starve_cnt  output  16  present only with IFQ_PERF_CNT_EN

Behaviour:
- Reset (async, any state): PC=RESET_PC; queue empty; outstanding=0; discard=0; state=IDLE.
- Outputs during/after reset: imem_req_valid=0, inst_valid=0, queue_count=0, inst_data/inst_pc=0, inst_pc_next=4, perf counters=0.
- Reset mid-operation: drops everything. Responses that arrive after reset are ignored only via outstanding=0 semantics. The memory is also reset by the same Reset.
- FSM states:
  - IDLE: one cycle after reset release, no request; -> FETCH.
  - FETCH: imem_req_valid=1 iff queue_count+outstanding < DEPTH. Request handshake: PC+=4 (wraps), outstanding+=1.
  - FLUSH: entered on redirect when stale requests exist; imem_req_valid=0; returns to FETCH when discard reaches 0.
- Responses:
  - Response with discard>0: dropped, discard-=1, outstanding-=1.
  - Response with discard=0: written to the queue tail with its own PC. The PC is tracked per outstanding request in a DEPTH-entry address FIFO.
- Queue: circular buffer with wrap-around pointers.
  - inst_valid = queue not empty; head outputs come from registers (no memory-to-ID combinational path).
  - Pop on inst_valid&&inst_ready.
  - Push and pop in the same cycle: count unchanged, legal when full.
  - Overflow is impossible by construction (the issue rule reserves space).
- Redirect (highest priority):
  - Queue cleared; PC=redirect_addr.
  - discard = outstanding_after_this_cycle: includes a request accepted in the same cycle, excludes a response consumed in the same cycle.
  - If the new discard>0 -> FLUSH, else -> FETCH.
  - Same-cycle request: the request address is the old PC; it is counted stale.
  - Same-cycle response: discarded.
  - Same-cycle pop: the handshake completes (ID owns killing it); the queue is then empty.
  - Redirect in FLUSH: PC updated, discard recomputed the same way, stays in FLUSH.
- Latency: request accept at cycle t, response at t+1 -> inst_valid at t+2.
- Throughput: 1 instruction/cycle with single-cycle memory and DEPTH>=2.

Optional Feature:
- IFQ_PERF_CNT_EN defined:
  - perf_flush_cnt increments on every redirect.
  - perf_starve_cnt increments each cycle in FETCH/FLUSH with inst_valid=0.
  - Both saturate at 16'hFFFF.
- Undefined: both ports and all counter logic are absent.

Test Plan:
- Reset release, memory always ready with 1-cycle latency, inst_ready=1 -> requests at 0,4,8,...; first inst_valid 2 cycles after the first request; inst_pc 0,4,8 on consecutive cycles; inst_pc_next=inst_pc+4.
- inst_ready=0, DEPTH=4 -> queue_count reaches 4, imem_req_valid=0, no 5th request. Then inst_ready=1 for one cycle -> exactly one new request issued, no data lost, order 0..16 preserved.
- Two requests outstanding (3-cycle memory latency), redirect to 0x100 -> FLUSH, both responses dropped, queue empty. Next request addr=0x100, first delivered inst_pc=0x100.
- Redirect coincident with a request handshake at PC=0x20 and a response -> 0x20 response and coincident response discarded. Next delivered inst_pc=redirect_addr.
- PC=2^ADDR_W-4 with ADDR_W=8 -> next request addr 0x00 (wrap).
- Assert Reset mid-FLUSH, then release -> all outputs at reset values, IDLE one cycle, first request at RESET_PC. With IFQ_PERF_CNT_EN: perf_flush_cnt=0 after reset and =3 after three redirects.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues in-order fetch requests,
// buffers returned instructions in a DEPTH-entry prefetch queue and flushes
// on branch/jump redirect while discarding stale in-flight responses.
// Optional build macro IFQ_PERF_CNT_EN adds flush/starve performance counters.
module inst_fetch_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     CLK,
  input  logic                     Reset,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDR_W-1:0]        imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [DATA_W-1:0]        imem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_addr,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [DATA_W-1:0]        inst_data,
  output logic [ADDR_W-1:0]        inst_pc,
  output logic [ADDR_W-1:0]        inst_pc_next,
  output logic [$clog2(DEPTH):0]   queue_count
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [15:0]              perf_flush_cnt,
  output logic [15:0]              perf_starve_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} ifqState;

  ifqState           state, stateNext;
  logic [ADDR_W-1:0] pc;
  logic [CW-1:0]     outstanding, outstandingNext;
  logic [CW-1:0]     discard, discardNext;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;

  logic [ADDR_W-1:0] addrFifo [DEPTH];
  logic [PW-1:0]     afWr, afRd;

  logic [DATA_W-1:0] qData [DEPTH];
  logic [ADDR_W-1:0] qPc [DEPTH];
  logic [PW-1:0]     qHead, qTail;

  logic reqFire, rspFire, push, pop;

  assign reqFire = imem_req_valid && imem_req_ready;
  // Responses with nothing outstanding (e.g. after reset) are ignored.
  assign rspFire = imem_rsp_valid && (outstanding != '0);
  assign push = rspFire && (discard == '0) && !redirect_valid;
  assign pop = inst_valid && inst_ready;
  assign outstandingNext = outstanding + CW'(reqFire) - CW'(rspFire);
  assign occupancy = {1'b0, count} + {1'b0, outstanding};

  assign imem_req_addr = pc;
  assign queue_count = count;
  assign inst_valid = (count != '0);
  assign inst_data = inst_valid ? qData[qHead] : '0;
  assign inst_pc = inst_valid ? qPc[qHead] : '0;
  assign inst_pc_next = inst_pc + ADDR_W'(4);

  // Stale-response budget: a redirect marks everything still in flight stale.
  always_comb begin
    discardNext = discard;
    if (redirect_valid) begin
      discardNext = outstandingNext;
    end else if (rspFire && (discard != '0)) begin
      discardNext = discard - CW'(1);
    end
  end

  // Next-state and request-issue logic; redirect overrides the normal flow.
  always_comb begin
    stateNext = state;
    imem_req_valid = 1'b0;
    unique case (state)
      IDLE:  stateNext = FETCH;
      FETCH: imem_req_valid = (occupancy < (CW+1)'(DEPTH));
      FLUSH: if (discardNext == '0) stateNext = FETCH;
      default: stateNext = IDLE;
    endcase
    if (redirect_valid) begin
      stateNext = (discardNext != '0) ? FLUSH : FETCH;
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else state <= stateNext;
  end

  // PC and in-flight bookkeeping.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
    end else begin
      if (redirect_valid) pc <= redirect_addr;
      else if (reqFire) pc <= pc + ADDR_W'(4);
      outstanding <= outstandingNext;
      discard <= discardNext;
    end
  end

  // Address FIFO pointers: one entry per accepted request, retired by its response.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      afWr <= '0;
      afRd <= '0;
    end else begin
      if (reqFire) afWr <= afWr + PW'(1);
      if (rspFire) afRd <= afRd + PW'(1);
    end
  end

  // Address FIFO storage.
  always_ff @(posedge CLK) begin
    if (reqFire) addrFifo[afWr] <= pc;
  end

  // Instruction queue storage; each entry carries the PC of its own request.
  always_ff @(posedge CLK) begin
    if (push) begin
      qData[qTail] <= imem_rsp_data;
      qPc[qTail] <= addrFifo[afRd];
    end
  end

  // Instruction queue pointers and occupancy; redirect empties the queue.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      qHead <= '0;
      qTail <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      qHead <= '0;
      qTail <= '0;
      count <= '0;
    end else begin
      if (push) qTail <= qTail + PW'(1);
      if (pop) qHead <= qHead + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef IFQ_PERF_CNT_EN
  // Saturating counters for redirects and cycles with nothing to hand to ID.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      perf_flush_cnt <= '0;
      perf_starve_cnt <= '0;
    end else begin
      if (redirect_valid && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
      if ((state == FETCH || state == FLUSH) && !inst_valid && (perf_starve_cnt != '1))
        perf_starve_cnt <= perf_starve_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue with a latency-programmable memory model.
module tb_inst_fetch_queue;

  logic        CLK;
  logic        Reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_next;
  logic [2:0]  queue_count;
`ifdef IFQ_PERF_CNT_EN
  logic [15:0] perf_flush_cnt;
  logic [15:0] perf_starve_cnt;
`endif

  inst_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .Reset(Reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_pc_next(inst_pc_next),
    .queue_count(queue_count)
`ifdef IFQ_PERF_CNT_EN
    , .perf_flush_cnt(perf_flush_cnt), .perf_starve_cnt(perf_starve_cnt)
`endif
  );

  int nTotal = 0;
  int nBad = 0;
  int nCyc = 0;
  int reqCnt = 0;
  int firstReq = -1;
  int firstVld = -1;
  int memLat = 1;
  logic memReady = 1'b1;
  logic [31:0] sbQ[$];
  logic [31:0] pendAddr[$];
  int pendDue[$];

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: decisions at negedge+1 apply to the following posedge.
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    forever begin
      @(negedge CLK);
      #1;
      nCyc++;
      if (Reset) begin
        pendAddr.delete();
        pendDue.delete();
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
      end else begin
        imem_req_ready = memReady;
        if (imem_req_valid && memReady) begin
          pendAddr.push_back(imem_req_addr);
          pendDue.push_back(nCyc + memLat);
          reqCnt++;
          if (firstReq < 0) firstReq = nCyc;
        end
        if (pendDue.size() != 0 && pendDue[0] <= nCyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data = memData(pendAddr.pop_front());
          void'(pendDue.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every ID handshake.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      #2;
      if (!Reset && inst_valid && firstVld < 0) firstVld = nCyc;
      if (!Reset && inst_valid && inst_ready) begin
        nTotal++;
        if (sbQ.size() == 0) begin
          nBad++;
          $display("FAIL unexpected_pop: got pc=%h want none", inst_pc);
        end else begin
          e = sbQ.pop_front();
          if (inst_pc !== e || inst_data !== memData(e) || inst_pc_next !== e + 32'd4) begin
            nBad++;
            $display("FAIL pop: got pc=%h data=%h next=%h want pc=%h data=%h next=%h",
                     inst_pc, inst_data, inst_pc_next, e, memData(e), e + 32'd4);
          end
        end
      end
    end
  end

  task automatic doReset();
    @(negedge CLK);
    Reset = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    memReady = 1'b1;
    repeat (3) @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic pushRange(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) sbQ.push_back(base + 32'(4 * i));
  endtask

  // Let the queue fill, then hand exactly four instructions to ID.
  task automatic fillDrain(input string name);
    repeat (12) @(negedge CLK);
    #2 chk({name, "_full"}, 32'(queue_count), 32'd4);
    @(negedge CLK);
    inst_ready = 1'b1;
    repeat (3) @(negedge CLK);
    @(negedge CLK);
    inst_ready = 1'b0;
    #3 chk({name, "_sb_empty"}, 32'(sbQ.size()), 32'd0);
  endtask

  task automatic chkResetOutputs();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_count", 32'(queue_count), 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_pc_next", inst_pc_next, 32'd4);
`ifdef IFQ_PERF_CNT_EN
    chk("rst_perf_flush", 32'(perf_flush_cnt), 32'd0);
    chk("rst_perf_starve", 32'(perf_starve_cnt), 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    Reset = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    repeat (2) @(negedge CLK);
    #2 chkResetOutputs();

    // Streaming from reset, then back-pressure to full, single pop, drain.
    memLat = 1;
    doReset();
    inst_ready = 1'b1;
    firstReq = -1;
    firstVld = -1;
    pushRange(32'h0, 10);
    #2 chk("idle_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge CLK);
    #2 chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    repeat (7) @(negedge CLK);
    inst_ready = 1'b0;
    repeat (6) @(negedge CLK);
    #2 chk("full_count", 32'(queue_count), 32'd4);
    chk("full_no_req", 32'(imem_req_valid), 32'd0);
    chk("first_latency", 32'(firstVld - firstReq), 32'd2);
    r0 = reqCnt;
    @(negedge CLK);
    inst_ready = 1'b1;
    @(negedge CLK);
    inst_ready = 1'b0;
    repeat (5) @(negedge CLK);
    #2 chk("one_refill_req", 32'(reqCnt - r0), 32'd1);
    chk("refill_count", 32'(queue_count), 32'd4);
    @(negedge CLK);
    inst_ready = 1'b1;
    repeat (3) @(negedge CLK);
    @(negedge CLK);
    inst_ready = 1'b0;
    #3 chk("stream_sb_empty", 32'(sbQ.size()), 32'd0);

    // Redirect with two outstanding requests on a 3-cycle memory.
    memLat = 3;
    doReset();
    repeat (3) @(negedge CLK);
    memReady = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 32'h100;
    @(negedge CLK);
    redirect_valid = 1'b0;
    memReady = 1'b1;
    #2 chk("flush_no_req_a", 32'(imem_req_valid), 32'd0);
    chk("flush_count", 32'(queue_count), 32'd0);
    @(negedge CLK);
    #2 chk("flush_no_req_b", 32'(imem_req_valid), 32'd0);
    @(negedge CLK);
    #2 chk("post_flush_req", 32'(imem_req_valid), 32'd1);
    chk("post_flush_addr", imem_req_addr, 32'h100);
    pushRange(32'h100, 4);
    fillDrain("flush");

    // Redirect coincident with request at 0x20, a response and a pop.
    memLat = 1;
    doReset();
    inst_ready = 1'b1;
    pushRange(32'h0, 7);
    repeat (9) @(negedge CLK);
    redirect_valid = 1'b1;
    redirect_addr = 32'h200;
    #2 chk("coinc_req_addr", imem_req_addr, 32'h20);
    chk("coinc_rsp_valid", 32'(imem_rsp_valid), 32'd1);
    @(negedge CLK);
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    #2 chk("coinc_flush", 32'(imem_req_valid), 32'd0);
    chk("coinc_empty", 32'(inst_valid), 32'd0);
    @(negedge CLK);
    #2 chk("coinc_next_addr", imem_req_addr, 32'h200);
    pushRange(32'h200, 4);
    fillDrain("coinc");

    // PC wrap-around at the top of the address space.
    memLat = 1;
    doReset();
    @(negedge CLK);
    memReady = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 32'hFFFF_FFF8;
    @(negedge CLK);
    redirect_valid = 1'b0;
    memReady = 1'b1;
    #2 chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFF8);
    sbQ.push_back(32'hFFFF_FFF8);
    sbQ.push_back(32'hFFFF_FFFC);
    sbQ.push_back(32'h0);
    sbQ.push_back(32'h4);
    fillDrain("wrap");

    // Reset asserted while flushing.
    memLat = 3;
    doReset();
    repeat (3) @(negedge CLK);
    memReady = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 32'h300;
    @(negedge CLK);
    redirect_valid = 1'b0;
    memReady = 1'b1;
    Reset = 1'b1;
    #2 chkResetOutputs();
    @(negedge CLK);
    Reset = 1'b0;
    #2 chk("rst2_idle", 32'(imem_req_valid), 32'd0);
    @(negedge CLK);
    #2 chk("rst2_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rst2_req_addr", imem_req_addr, 32'h0);
    pushRange(32'h0, 4);
    fillDrain("rst2");

`ifdef IFQ_PERF_CNT_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      redirect_valid = 1'b1;
      redirect_addr = 32'h40;
      @(negedge CLK);
      redirect_valid = 1'b0;
    end
    #2 chk("perf_flush_3", 32'(perf_flush_cnt), 32'd3);
`endif

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
